// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared definitions for the posting store buffer.
//   sb_entry_t     : one buffered store {word address, data} at default widths
//   SB_DEPTH/AW/DW : default buffer depth, address width and data width
//   sb_ptr_width   : head/tail pointer width for a given depth
//   sb_cnt_width   : occupancy counter width (must be able to hold DEPTH itself)
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // Stores are word-only, so the two low address bits are never kept.
  typedef struct packed {
    logic [SB_AW-3:0] word;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int sb_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo
// Circular storage for the store buffer: entry arrays, head/tail pointers and
// an occupancy count. The whole array is exposed so the parent can search it.
// Ports:
//   clk, reset   : core clock, asynchronous active-low reset
//   push         : write {push_word, push_data} at the tail (never when full)
//   pop          : retire the head entry (never when empty)
//   entry_word   : word address of every slot
//   entry_data   : data of every slot
//   entry_valid  : per-slot occupancy mask
//   head_ptr     : slot index of the oldest entry
//   count        : number of occupied slots, 0..DEPTH
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int  DEPTH = SB_DEPTH,
  parameter int  AW    = SB_AW,
  parameter int  DW    = SB_DW,
  localparam int PW    = sb_ptr_width(DEPTH),
  localparam int CW    = sb_cnt_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [AW-3:0]             push_word,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  output logic [DEPTH-1:0][AW-3:0]  entry_word,
  output logic [DEPTH-1:0][DW-1:0]  entry_data,
  output logic [DEPTH-1:0]          entry_valid,
  output logic [PW-1:0]             head_ptr,
  output logic [CW-1:0]             count
);

  logic [PW-1:0] tail_ptr;

  // Pointer and count bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Entry storage is deliberately left out of reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_word[tail_ptr] <= push_word;
      entry_data[tail_ptr] <= push_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PW'(i) - head_ptr} < count;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// Posting write buffer between the core's data port and a slower memory.
// Stores are captured in one cycle and retired through a valid/ready port;
// loads read memory combinationally with younger buffered stores forwarded.
// Configuration macro: STORE_BUFFER_FWD_EN
//   defined   : youngest matching entry is forwarded onto rdata, loads never stall
//   undefined : rdata = mem_rdata, and a load hitting any pending entry stalls
//               until the buffer has drained every matching entry
// Ports:
//   clk, reset            : core clock, asynchronous active-low reset
//   mem_write, mem_read   : core store / load request
//   addr, wdata           : byte address (bits [1:0] ignored) and store data
//   rdata                 : load data to the core
//   stall                 : core holds PC and suppresses writeback
//   sb_empty              : no pending stores
//   mem_raddr, mem_rdata  : combinational memory read port
//   wr_valid, wr_ready    : head entry handshake to memory
//   wr_addr, wr_data      : head entry address and data
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_write,
  input  logic          mem_read,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          sb_empty,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);

  localparam int PW = sb_ptr_width(DEPTH);
  localparam int CW = sb_cnt_width(DEPTH);

  logic [DEPTH-1:0][AW-3:0] entry_word;
  logic [DEPTH-1:0][DW-1:0] entry_data;
  logic [DEPTH-1:0]         entry_valid;
  logic [PW-1:0]            head_ptr;
  logic [CW-1:0]            count;
  logic [PW-1:0]            scan_idx;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     hit;
`ifdef STORE_BUFFER_FWD_EN
  logic [DW-1:0]            fwd_data;
`endif

  sb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_word   (addr[AW-1:2]),
    .push_data   (wdata),
    .pop         (pop),
    .entry_word  (entry_word),
    .entry_data  (entry_data),
    .entry_valid (entry_valid),
    .head_ptr    (head_ptr),
    .count       (count)
  );

  assign mem_raddr = addr;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign wr_valid  = !empty;
  assign sb_empty  = empty;
  assign wr_addr   = {entry_word[head_ptr], 2'b00};
  assign wr_data   = entry_data[head_ptr];
  assign push      = mem_write && !stall;
  assign pop       = wr_valid && wr_ready;

  // Scan oldest to youngest so the last hit is the youngest match. A head
  // entry being popped this cycle is still valid here and still counts.
  always_comb begin
    hit      = 1'b0;
    scan_idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_ptr + PW'(i);
      if (entry_valid[scan_idx] && (entry_word[scan_idx] == addr[AW-1:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        fwd_data = entry_data[scan_idx];
`endif
      end
    end
  end

  // Full blocks a store even if the head retires this cycle (no full bypass).
  // Without forwarding, a load that hits pending data waits for it to drain.
  always_comb begin
`ifdef STORE_BUFFER_FWD_EN
    stall = mem_write && full;
    rdata = (mem_read && hit) ? fwd_data : mem_rdata;
`else
    stall = (mem_write && full) || (mem_read && !mem_write && hit);
    rdata = mem_rdata;
`endif
  end

  // A load and a store together is a core bug; the store is the one taken.
  a_no_load_store: assert property (@(posedge clk) disable iff (!reset)
    !(mem_read && mem_write));

endmodule
